// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: ALU control codes, opcodes, funct fields and the decoded bundle.
package rv32_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SHAMT
    } imm_type_e;

    typedef struct packed {
        logic [3:0]           alu_ctrl;
        logic                 a_sel_pc;
        logic                 b_sel_imm;
        logic [XLEN-1:0]      imm;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic [2:0]           funct3;
        logic                 branch;
        logic                 jump;
        logic                 illegal;
    } dec_bundle_t;

    // funct3 -> ALU operation for OP / OP-IMM; alt selects sub/sra.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] r;
        unique case (f3)
            F3_ADD_SUB: r = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     r = ALU_SLL;
            F3_SLT:     r = ALU_SLT;
            F3_SLTU:    r = ALU_SLTU;
            F3_XOR:     r = ALU_XOR;
            F3_SR:      r = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      r = ALU_OR;
            default:    r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction and sign extension for all RV32I formats.
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm_c
);

    always_comb begin
        imm_c = '0;
        unique case (imm_type)
            IMM_I:     imm_c = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm_c = {instr[31:12], 12'b0};
            IMM_J:     imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: imm_c = {27'b0, instr[24:20]};
            default:   imm_c = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: single-entry registered bundle with valid/ready on both sides and flush.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      alu_ctrl,
    output logic            a_sel_pc,
    output logic            b_sel_imm,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic [2:0]      funct3,
    output logic            branch,
    output logic            jump,
    output logic            illegal
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e          state;
    dec_bundle_t     bundle_q;
    logic [XLEN-1:0] pc_q;

    dec_bundle_t dec;
    dec_bundle_t dec_full;
    imm_type_e   imm_type;
    logic [31:0] imm_val;
    logic        accept;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    imm_gen u_imm_gen (
        .instr    (in_instr[31:7]),
        .imm_type (imm_type),
        .imm_c    (imm_val)
    );

    // Field decode; an illegal encoding collapses to an inert add bundle.
    always_comb begin
        dec          = '0;
        imm_type     = IMM_NONE;
        dec.alu_ctrl = ALU_ADD;
        dec.funct3   = f3;
        unique case (opcode)
            OPC_OP: begin
                dec.rs1       = in_instr[19:15];
                dec.rs2       = in_instr[24:20];
                dec.rd        = in_instr[11:7];
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_from_f3(f3, f7[5]);
                dec.illegal   = !((f7 == F7_ZERO) ||
                                  ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SR))));
            end
            OPC_OP_IMM: begin
                imm_type      = ((f3 == F3_SLL) || (f3 == F3_SR)) ? IMM_SHAMT : IMM_I;
                dec.b_sel_imm = 1'b1;
                dec.rs1       = in_instr[19:15];
                dec.rd        = in_instr[11:7];
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_from_f3(f3, (f3 == F3_SR) && f7[5]);
                if (f3 == F3_SLL)
                    dec.illegal = (f7 != F7_ZERO);
                else if (f3 == F3_SR)
                    dec.illegal = (f7 != F7_ZERO) && (f7 != F7_ALT);
            end
            OPC_LOAD: begin
                imm_type      = IMM_I;
                dec.b_sel_imm = 1'b1;
                dec.rs1       = in_instr[19:15];
                dec.rd        = in_instr[11:7];
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.illegal   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                imm_type      = IMM_S;
                dec.b_sel_imm = 1'b1;
                dec.rs1       = in_instr[19:15];
                dec.rs2       = in_instr[24:20];
                dec.mem_write = 1'b1;
                dec.illegal   = (f3 > 3'b010);
            end
            OPC_BRANCH: begin
                imm_type   = IMM_B;
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.branch = 1'b1;
                unique case (f3[2:1])
                    2'b00:   dec.alu_ctrl = ALU_SUB;
                    2'b10:   dec.alu_ctrl = ALU_SLT;
                    2'b11:   dec.alu_ctrl = ALU_SLTU;
                    default: dec.illegal  = 1'b1;
                endcase
            end
            OPC_JAL: begin
                imm_type      = IMM_J;
                dec.a_sel_pc  = 1'b1;
                dec.b_sel_imm = 1'b1;
                dec.rd        = in_instr[11:7];
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
            end
            OPC_JALR: begin
                imm_type      = IMM_I;
                dec.b_sel_imm = 1'b1;
                dec.rs1       = in_instr[19:15];
                dec.rd        = in_instr[11:7];
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
            end
            OPC_LUI: begin
                imm_type      = IMM_U;
                dec.b_sel_imm = 1'b1;
                dec.rd        = in_instr[11:7];
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                imm_type      = IMM_U;
                dec.a_sel_pc  = 1'b1;
                dec.b_sel_imm = 1'b1;
                dec.rd        = in_instr[11:7];
                dec.reg_write = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec          = '0;
            dec.illegal  = 1'b1;
            dec.alu_ctrl = ALU_ADD;
            dec.funct3   = f3;
            imm_type     = IMM_NONE;
        end
    end

    always_comb begin
        dec_full     = dec;
        dec_full.imm = imm_val;
    end

    assign in_ready = !flush && ((state == EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;

    // Stage occupancy and bundle register; flush beats any accept or drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            pc_q     <= RESET_PC;
            bundle_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state    <= FULL;
                        bundle_q <= dec_full;
                        pc_q     <= in_pc;
                    end
                end
                default: begin
                    if (accept) begin
                        bundle_q <= dec_full;
                        pc_q     <= in_pc;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
            endcase
        end
    end

    assign out_valid = (state == FULL);
    assign out_pc    = pc_q;
    assign alu_ctrl  = bundle_q.alu_ctrl;
    assign a_sel_pc  = bundle_q.a_sel_pc;
    assign b_sel_imm = bundle_q.b_sel_imm;
    assign imm       = bundle_q.imm;
    assign rs1       = bundle_q.rs1;
    assign rs2       = bundle_q.rs2;
    assign rd        = bundle_q.rd;
    assign reg_write = bundle_q.reg_write;
    assign mem_read  = bundle_q.mem_read;
    assign mem_write = bundle_q.mem_write;
    assign funct3    = bundle_q.funct3;
    assign branch    = bundle_q.branch;
    assign jump      = bundle_q.jump;
    assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus random traffic against a behavioural model.
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, imm;
    logic [3:0]  alu_ctrl;
    logic        a_sel_pc, b_sel_imm, reg_write, mem_read, mem_write, branch, jump, illegal;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0]  alu;
        logic        a_pc;
        logic        b_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic        br;
        logic        jmp;
        logic        ill;
    } exp_t;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .alu_ctrl(alu_ctrl), .a_sel_pc(a_sel_pc), .b_sel_imm(b_sel_imm),
        .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .branch(branch), .jump(jump), .illegal(illegal)
    );

    function automatic exp_t observed();
        return {alu_ctrl, a_sel_pc, b_sel_imm, imm, rs1, rs2, rd, reg_write, mem_read,
                mem_write, funct3, branch, jump, illegal};
    endfunction

    // Reference decode built from the ISA tables with signed arithmetic.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        logic [3:0] tbl [8] = '{4'd0, 4'd2, 4'd3, 4'd9, 4'd4, 4'd5, 4'd6, 4'd7};
        logic [6:0] op = ins[6:0];
        int f3 = int'(ins[14:12]);
        int f7 = int'(ins[31:25]);
        logic signed [11:0] ti = ins[31:20];
        logic signed [11:0] ts = {ins[31:25], ins[11:7]};
        logic signed [12:0] tb = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        logic signed [20:0] tj = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        bit legal = 1'b1;
        bit shift;
        e = '0;
        e.f3 = ins[14:12];
        case (op)
            7'h33: begin
                legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                e.alu = (f7 == 32 && f3 == 0) ? 4'd1 : (f7 == 32 && f3 == 5) ? 4'd8 : tbl[f3];
                e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.rw = 1;
            end
            7'h13: begin
                shift = (f3 == 1) || (f3 == 5);
                legal = !shift || (f7 == 0) || (f3 == 5 && f7 == 32);
                e.alu = (f3 == 5 && f7 == 32) ? 4'd8 : tbl[f3];
                e.imm = shift ? 32'(ins[24:20]) : 32'(ti);
                e.b_imm = 1; e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.rw = 1;
            end
            7'h03: begin
                legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
                e.imm = 32'(ti); e.b_imm = 1; e.rs1 = ins[19:15]; e.rd = ins[11:7];
                e.rw = 1; e.mr = 1;
            end
            7'h23: begin
                legal = f3 <= 2;
                e.imm = 32'(ts); e.b_imm = 1; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.mw = 1;
            end
            7'h63: begin
                legal = (f3 != 2) && (f3 != 3);
                e.alu = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd3 : 4'd9;
                e.imm = 32'(tb); e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.br = 1;
            end
            7'h6F: begin
                e.imm = 32'(tj); e.a_pc = 1; e.b_imm = 1; e.rd = ins[11:7]; e.rw = 1; e.jmp = 1;
            end
            7'h67: begin
                e.imm = 32'(ti); e.b_imm = 1; e.rs1 = ins[19:15]; e.rd = ins[11:7];
                e.rw = 1; e.jmp = 1;
            end
            7'h37: begin
                e.imm = ins & 32'hFFFF_F000; e.b_imm = 1; e.rd = ins[11:7]; e.rw = 1;
            end
            7'h17: begin
                e.imm = ins & 32'hFFFF_F000; e.a_pc = 1; e.b_imm = 1; e.rd = ins[11:7]; e.rw = 1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e = '0;
            e.ill = 1;
            e.f3 = ins[14:12];
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; out_ready = 0; in_instr = '0; in_pc = '0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_pc !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", out_pc, RST_PC); end
        total++; if (observed() !== exp_t'(0)) begin bad++; $display("FAIL reset_outputs got=%h exp=0", observed()); end
        rst = 0; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h100; out_ready = 1;
        tick(); in_valid = 0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        total++; if ({alu_ctrl, rd, rs1, rs2, b_sel_imm, reg_write} !== {4'b0000, 5'd3, 5'd1, 5'd2, 1'b0, 1'b1})
            begin bad++; $display("FAIL add_fields got=%h/%0d/%0d/%0d/%b/%b", alu_ctrl, rd, rs1, rs2, b_sel_imm, reg_write); end
        total++; if (out_pc !== 32'h100) begin bad++; $display("FAIL add_pc got=%h exp=100", out_pc); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1; in_valid = 1; in_instr = 32'h402081B3; in_pc = 32'h10;
        tick();
        total++; if ({out_valid, alu_ctrl} !== {1'b1, 4'b0001}) begin bad++; $display("FAIL sub got=%b/%h exp=1/1", out_valid, alu_ctrl); end
        in_instr = 32'h40335293; in_pc = 32'h14;
        tick(); in_valid = 0;
        total++; if ({out_valid, alu_ctrl, imm, b_sel_imm} !== {1'b1, 4'b1000, 32'd3, 1'b1})
            begin bad++; $display("FAIL srai got=%b/%h/%h/%b exp=1/8/3/1", out_valid, alu_ctrl, imm, b_sel_imm); end
        total++; if (out_pc !== 32'h14) begin bad++; $display("FAIL srai_pc got=%h exp=14", out_pc); end
        tick();
    endtask

    task automatic test_branch();
        out_ready = 1; in_valid = 1; in_instr = 32'hFE208EE3; in_pc = 32'h40;
        tick(); in_valid = 0;
        total++; if ({alu_ctrl, imm, branch, reg_write, rd} !== {4'b0001, 32'hFFFF_FFFC, 1'b1, 1'b0, 5'd0})
            begin bad++; $display("FAIL beq got=%h/%h/%b/%b/%0d", alu_ctrl, imm, branch, reg_write, rd); end
        tick();
    endtask

    task automatic test_backpressure();
        exp_t held, nxt;
        held = model(32'h002081B3);
        nxt  = model(32'h402081B3);
        out_ready = 0; in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h200;
        tick();
        in_instr = 32'h402081B3; in_pc = 32'h204; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({out_valid, out_pc, observed()} !== {1'b1, 32'h200, held})
                begin bad++; $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/200/%h", i, out_valid, out_pc, observed(), held); end
        end
        out_ready = 1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
        tick(); in_valid = 0;
        total++; if ({out_valid, out_pc, observed()} !== {1'b1, 32'h204, nxt})
            begin bad++; $display("FAIL bp_next got=%b/%h/%h exp=1/204/%h", out_valid, out_pc, observed(), nxt); end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h300;
        tick();
        flush = 1; out_ready = 1; in_instr = 32'h402081B3; in_pc = 32'h304; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        tick(); flush = 0; in_valid = 0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_noaccept got=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal_reset();
        out_ready = 0; in_valid = 1; in_instr = 32'h0000000B; in_pc = 32'h400;
        tick(); in_valid = 0;
        total++; if ({out_valid, illegal, alu_ctrl, reg_write} !== {1'b1, 1'b1, 4'b0000, 1'b0})
            begin bad++; $display("FAIL illegal got=%b/%b/%h/%b exp=1/1/0/0", out_valid, illegal, alu_ctrl, reg_write); end
        rst = 1; tick(); rst = 0;
        total++; if ({out_valid, out_pc} !== {1'b0, RST_PC})
            begin bad++; $display("FAIL reset_full got=%b/%h exp=0/%h", out_valid, out_pc, RST_PC); end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0B, 7'h73};
        logic [31:0] r = $urandom;
        int k = $urandom_range(0, 2);
        r[6:0] = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
        if (k == 0) r[31:25] = 7'h00;
        else if (k == 1) r[31:25] = 7'h20;
        return r;
    endfunction

    task automatic test_random();
        bit          m_valid = 0;
        exp_t        m_bundle = '0;
        logic [31:0] m_pc = RST_PC;
        bit          acc;
        for (int c = 0; c < 600; c++) begin
            total++;
            if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, m_valid); end
            if (m_valid) begin
                total++;
                if ({out_pc, observed()} !== {m_pc, m_bundle})
                    begin bad++; $display("FAIL rnd_bundle c=%0d got=%h/%h exp=%h/%h", c, out_pc, observed(), m_pc, m_bundle); end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            #1;
            acc = !flush && (!m_valid || out_ready);
            total++;
            if (in_ready !== acc) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, acc); end
            if (flush) m_valid = 0;
            else if (acc && in_valid) begin m_valid = 1; m_bundle = model(in_instr); m_pc = in_pc; end
            else if (out_ready) m_valid = 0;
            tick();
        end
        idle();
    endtask

    initial begin
        rst = 1; idle();
        test_reset();
        test_add();
        test_back_to_back();
        test_branch();
        test_backpressure();
        test_flush();
        test_illegal_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
